// File: rtl/mem_bus_controller.sv
// Single-owner sequencer for main SRAM, the UART data/status registers and the
// graphic-card write port; arbitrates fetch and data requests, one access at a time.
module mem_bus_controller #(
   parameter int RAM_WAIT    = 1,
   parameter int UART_STROBE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_ack,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata,
   output logic        ram_data_oe,
   output logic        ram_en_n,
   output logic        ram_oe_n,
   output logic        ram_we_n,
   input  logic [7:0]  uart_rdata,
   input  logic        uart_data_ready,
   input  logic        uart_tbre,
   input  logic        uart_tsre,
   output logic        uart_rdn,
   output logic        uart_wrn,
   output logic [7:0]  uart_wdata,
   output logic        vga_we,
   output logic [15:0] vga_wdata
);

   typedef enum logic [2:0] {
      IDLE, RAM_RD, RAM_WR, UART_RD, UART_WR, FINISH
   } state_t;

   localparam logic [15:0] ADDR_UART_DATA = 16'hBF00;
   localparam logic [15:0] ADDR_UART_STAT = 16'hBF01;
   localparam logic [15:0] ADDR_VGA       = 16'hBF0A;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic        src_mem_reg, src_mem_next;
   logic [15:0] ram_addr_reg, ram_addr_next;
   logic [15:0] ram_wdata_reg, ram_wdata_next;
   logic [7:0]  uart_wdata_reg, uart_wdata_next;
   logic [15:0] vga_wdata_reg, vga_wdata_next;
   logic [15:0] if_rdata_reg, mem_rdata_reg;
   logic        if_ack_reg, mem_ack_reg, vga_we_reg;
   logic        ram_en_n_reg, ram_oe_n_reg, ram_we_n_reg, ram_data_oe_reg;
   logic        uart_rdn_reg, uart_wrn_reg;
   logic [15:0] cap_data;
   logic        cap_en;
   logic        vga_hit;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      src_mem_next    = src_mem_reg;
      ram_addr_next   = ram_addr_reg;
      ram_wdata_next  = ram_wdata_reg;
      uart_wdata_next = uart_wdata_reg;
      vga_wdata_next  = vga_wdata_reg;
      cap_data        = 16'h0000;
      cap_en          = 1'b0;
      vga_hit         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mem_req) begin
               src_mem_next = 1'b1;
               if (mem_addr == ADDR_UART_DATA) begin
                  state_next = mem_we ? UART_WR : UART_RD;
                  cnt_next   = 3'(UART_STROBE - 1);
                  if (mem_we)
                     uart_wdata_next = mem_wdata[7:0];
               end else if (mem_addr == ADDR_UART_STAT) begin
                  // Status is sampled now; a write here is simply dropped.
                  state_next = FINISH;
                  cap_en     = !mem_we;
                  cap_data   = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
               end else if (mem_addr == ADDR_VGA) begin
                  state_next = FINISH;
                  cap_en     = !mem_we;
                  vga_hit    = mem_we;
                  if (mem_we)
                     vga_wdata_next = mem_wdata;
               end else begin
                  state_next    = mem_we ? RAM_WR : RAM_RD;
                  cnt_next      = 3'(RAM_WAIT);
                  ram_addr_next = mem_addr;
                  if (mem_we)
                     ram_wdata_next = mem_wdata;
               end
            end else if (if_req) begin
               src_mem_next  = 1'b0;
               state_next    = RAM_RD;
               cnt_next      = 3'(RAM_WAIT);
               ram_addr_next = if_addr;
            end
         end
         RAM_RD, UART_RD: begin
            if (cnt_reg == 3'd0) begin
               state_next = FINISH;
               cap_en     = 1'b1;
               cap_data   = (state_reg == RAM_RD) ? ram_rdata : {8'h00, uart_rdata};
            end else begin
               cnt_next = cnt_reg - 3'd1;
            end
         end
         RAM_WR, UART_WR: begin
            if (cnt_reg == 3'd0)
               state_next = FINISH;
            else
               cnt_next = cnt_reg - 3'd1;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes and acks are registered from the next state so every pin is glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= 3'd0;
         src_mem_reg     <= 1'b0;
         ram_addr_reg    <= 16'h0000;
         ram_wdata_reg   <= 16'h0000;
         uart_wdata_reg  <= 8'h00;
         vga_wdata_reg   <= 16'h0000;
         if_rdata_reg    <= 16'h0000;
         mem_rdata_reg   <= 16'h0000;
         if_ack_reg      <= 1'b0;
         mem_ack_reg     <= 1'b0;
         vga_we_reg      <= 1'b0;
         ram_en_n_reg    <= 1'b1;
         ram_oe_n_reg    <= 1'b1;
         ram_we_n_reg    <= 1'b1;
         ram_data_oe_reg <= 1'b0;
         uart_rdn_reg    <= 1'b1;
         uart_wrn_reg    <= 1'b1;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         src_mem_reg     <= src_mem_next;
         ram_addr_reg    <= ram_addr_next;
         ram_wdata_reg   <= ram_wdata_next;
         uart_wdata_reg  <= uart_wdata_next;
         vga_wdata_reg   <= vga_wdata_next;
         if_ack_reg      <= (state_next == FINISH) && !src_mem_next;
         mem_ack_reg     <= (state_next == FINISH) && src_mem_next;
         vga_we_reg      <= vga_hit;
         ram_en_n_reg    <= !((state_next == RAM_RD) || (state_next == RAM_WR));
         ram_oe_n_reg    <= !(state_next == RAM_RD);
         ram_we_n_reg    <= !(state_next == RAM_WR);
         // Keep driving the data bus through FINISH so write data outlives we_n.
         ram_data_oe_reg <= (state_next == RAM_WR) ||
                            ((state_next == FINISH) && (state_reg == RAM_WR));
         uart_rdn_reg    <= !(state_next == UART_RD);
         uart_wrn_reg    <= !(state_next == UART_WR);
         if (cap_en && src_mem_next)
            mem_rdata_reg <= cap_data;
         if (cap_en && !src_mem_next)
            if_rdata_reg <= cap_data;
      end
   end

   assign if_rdata    = if_rdata_reg;
   assign if_ack      = if_ack_reg;
   assign mem_rdata   = mem_rdata_reg;
   assign mem_ack     = mem_ack_reg;
   assign ram_addr    = ram_addr_reg;
   assign ram_wdata   = ram_wdata_reg;
   assign ram_data_oe = ram_data_oe_reg;
   assign ram_en_n    = ram_en_n_reg;
   assign ram_oe_n    = ram_oe_n_reg;
   assign ram_we_n    = ram_we_n_reg;
   assign uart_rdn    = uart_rdn_reg;
   assign uart_wrn    = uart_wrn_reg;
   assign uart_wdata  = uart_wdata_reg;
   assign vga_we      = vga_we_reg;
   assign vga_wdata   = vga_wdata_reg;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: directed and random transactions checked against
// a transaction-level model of latency, strobe widths and returned data.
module tb_mem_bus_controller;

   localparam int RW = 1;
   localparam int US = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we;
   logic [15:0] if_addr, mem_addr, mem_wdata, ram_rdata;
   logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata, vga_wdata;
   logic        if_ack, mem_ack, ram_data_oe, ram_en_n, ram_oe_n, ram_we_n;
   logic [7:0]  uart_rdata, uart_wdata;
   logic        uart_data_ready, uart_tbre, uart_tsre, uart_rdn, uart_wrn, vga_we;

   always #5 clk = ~clk;

   mem_bus_controller #(.RAM_WAIT(RW), .UART_STROBE(US)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_data_oe(ram_data_oe), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
      .uart_rdata(uart_rdata), .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre),
      .uart_tsre(uart_tsre), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_wdata(uart_wdata),
      .vga_we(vga_we), .vga_wdata(vga_wdata)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      int          lat;
      bit          mem_port;
      bit          rd;
      logic [15:0] rdata;
      int          n_oe, n_we, n_en, n_rdn, n_wrn, n_vga, n_doe;
      logic [15:0] ram_addr, ram_wdata, vga_wdata;
      logic [7:0]  uart_wdata;
   } exp_t;

   // What one transaction should look like on the pins, from the address map rules.
   function automatic exp_t model(bit is_mem, bit we, logic [15:0] addr, logic [15:0] wdata);
      exp_t e;
      e = '{default: 0};
      e.mem_port = is_mem;
      e.rd       = !(is_mem && we);
      if (is_mem && addr == 16'hBF00) begin
         e.lat = US + 1;
         if (we) begin e.n_wrn = US; e.uart_wdata = wdata[7:0]; end
         else begin e.n_rdn = US; e.rdata = {8'h00, uart_rdata}; end
      end else if (is_mem && addr == 16'hBF01) begin
         e.lat   = 1;
         e.rdata = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
      end else if (is_mem && addr == 16'hBF0A) begin
         e.lat = 1;
         if (we) begin e.n_vga = 1; e.vga_wdata = wdata; end
      end else begin
         e.lat      = RW + 2;
         e.n_en     = RW + 1;
         e.ram_addr = addr;
         if (e.rd) begin e.n_oe = RW + 1; e.rdata = ram_rdata; end
         else begin e.n_we = RW + 1; e.n_doe = RW + 2; e.ram_wdata = wdata; end
      end
      return e;
   endfunction

   int txn_id = 0;

   task automatic run_txn(input bit is_mem, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata);
      exp_t e;
      int lat = 0, n_oe = 0, n_we = 0, n_en = 0, n_rdn = 0, n_wrn = 0, n_vga = 0, n_doe = 0;
      int n_mack = 0, n_iack = 0;
      logic [15:0] o_addr = 0, o_wdata = 0, o_vga = 0, o_rdata = 0;
      logic [7:0]  o_uw = 0;
      string t;
      @(posedge clk);
      @(negedge clk);
      e = model(is_mem, we, addr, wdata);
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (!ram_oe_n) n_oe++;
         if (!ram_we_n) begin n_we++; o_wdata = ram_wdata; end
         if (!ram_en_n) begin n_en++; o_addr = ram_addr; end
         if (!uart_rdn) n_rdn++;
         if (!uart_wrn) begin n_wrn++; o_uw = uart_wdata; end
         if (vga_we) begin n_vga++; o_vga = vga_wdata; end
         if (ram_data_oe) n_doe++;
         if (mem_ack) n_mack++;
         if (if_ack) n_iack++;
         if (mem_ack || if_ack) begin
            lat = cyc;
            o_rdata = e.mem_port ? mem_rdata : if_rdata;
            break;
         end
      end
      mem_req = 1'b0;
      if_req  = 1'b0;
      $display("txn %0d: %s %s addr=%04h wdata=%04h lat=%0d rdata=%04h", txn_id,
               is_mem ? "MEM" : "IF", we ? "wr" : "rd", addr, wdata, lat, o_rdata);
      t = $sformatf("txn%0d", txn_id);
      check({t, " latency"}, lat, e.lat);
      check({t, " ack_port"}, {n_mack, n_iack}, e.mem_port ? {32'd1, 32'd0} : {32'd0, 32'd1});
      check({t, " ram_oe_n_low"}, n_oe, e.n_oe);
      check({t, " ram_we_n_low"}, n_we, e.n_we);
      check({t, " ram_en_n_low"}, n_en, e.n_en);
      check({t, " ram_data_oe"}, n_doe, e.n_doe);
      check({t, " uart_rdn_low"}, n_rdn, e.n_rdn);
      check({t, " uart_wrn_low"}, n_wrn, e.n_wrn);
      check({t, " vga_we"}, n_vga, e.n_vga);
      check({t, " ram_addr"}, o_addr, e.ram_addr);
      check({t, " ram_wdata"}, o_wdata, e.ram_wdata);
      check({t, " uart_wdata"}, o_uw, e.uart_wdata);
      check({t, " vga_wdata"}, o_vga, e.vga_wdata);
      if (e.rd) check({t, " rdata"}, o_rdata, e.rdata);
      txn_id++;
   endtask

   initial begin
      int mem_cyc, if_cyc, n_we, got_we, n_ack;
      logic [15:0] o_wd;
      rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0;
      if_addr = 0; mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
      uart_rdata = 0; uart_data_ready = 0; uart_tbre = 0; uart_tsre = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
      check("reset flags", {ram_data_oe, if_ack, mem_ack, vga_we}, 4'b0000);
      check("reset data", {ram_addr, ram_wdata, vga_wdata, if_rdata, mem_rdata, uart_wdata},
            88'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases from the address map.
      ram_rdata = 16'h1234;
      run_txn(0, 0, 16'h0010, 16'h0000);
      uart_data_ready = 1; uart_tbre = 1; uart_tsre = 0;
      run_txn(1, 0, 16'hBF01, 16'h0000);
      uart_tsre = 1;
      run_txn(1, 0, 16'hBF01, 16'h0000);
      uart_rdata = 8'h5A;
      run_txn(1, 0, 16'hBF00, 16'h0000);
      run_txn(1, 1, 16'hBF00, 16'h1241);
      run_txn(1, 1, 16'hBF0A, 16'h00FF);
      run_txn(1, 0, 16'hBF0A, 16'h0000);
      run_txn(1, 1, 16'hBF01, 16'hFFFF);

      // Simultaneous requests: data write wins, fetch follows.
      @(posedge clk);
      @(negedge clk);
      ram_rdata = 16'hC0DE;
      mem_req = 1; mem_we = 1; mem_addr = 16'h0020; mem_wdata = 16'hBEEF;
      if_req = 1; if_addr = 16'h0044;
      mem_cyc = 0; if_cyc = 0; n_we = 0; o_wd = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (!ram_we_n) begin n_we++; o_wd = ram_wdata; end
         if (mem_ack) begin mem_cyc = cyc; mem_req = 0; end
         if (if_ack) begin if_cyc = cyc; if_req = 0; break; end
      end
      mem_req = 0; if_req = 0;
      $display("arb: mem_ack@%0d if_ack@%0d if_rdata=%04h", mem_cyc, if_cyc, if_rdata);
      check("arb mem_ack cycle", mem_cyc, RW + 2);
      check("arb if_ack cycle", if_cyc, mem_cyc + RW + 3);
      check("arb we_n width", n_we, RW + 1);
      check("arb ram_wdata", o_wd, 16'hBEEF);
      check("arb if_rdata", if_rdata, 16'hC0DE);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a;
         int sel;
         sel = $urandom_range(0, 5);
         a = (sel == 0) ? 16'hBF00 : (sel == 1) ? 16'hBF01 : (sel == 2) ? 16'hBF0A
                                                             : 16'($urandom_range(0, 16'hBEFF));
         ram_rdata       = 16'($urandom);
         uart_rdata      = 8'($urandom);
         uart_data_ready = 1'($urandom);
         uart_tbre       = 1'($urandom);
         uart_tsre       = 1'($urandom);
         run_txn($urandom_range(0, 3) != 0, 1'($urandom), a, 16'($urandom));
      end

      // Reset in the middle of a write strobe, with a read pending behind it.
      @(posedge clk);
      @(negedge clk);
      mem_req = 1; mem_we = 1; mem_addr = 16'h0123; mem_wdata = 16'h5555;
      got_we = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk);
         #1;
         if (!ram_we_n) begin got_we = 1; break; end
      end
      check("rst write started", got_we, 1);
      rst = 1; mem_we = 0; mem_addr = 16'h0456; ram_rdata = 16'hA5A5;
      @(posedge clk);
      #1;
      check("rst strobes", {ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 5'b11111);
      check("rst flags", {ram_data_oe, if_ack, mem_ack, vga_we}, 4'b0000);
      rst = 0;
      mem_cyc = 0; n_ack = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk);
         #1;
         if (mem_ack) begin mem_cyc = cyc; n_ack++; break; end
      end
      mem_req = 0;
      $display("post-rst read: mem_ack@%0d mem_rdata=%04h", mem_cyc, mem_rdata);
      check("post-rst latency", mem_cyc, RW + 2);
      check("post-rst rdata", mem_rdata, 16'hA5A5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
